// File: rtl/bounce_gen.sv
// Mechanical-switch emulator: on start, drives LFSR-timed bounce segments on sw_o,
// then holds the target level for a settle period. Optional macro: BOUNCE_GEN_SEED_LOAD_EN.
module bounce_gen #(
  parameter int unsigned N_BOUNCES     = 8,
  parameter int unsigned MIN_DELAY     = 1,
  parameter int unsigned MAX_DELAY     = 16,
  parameter int unsigned SETTLE_CYCLES = 30,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        level_i,
`ifdef BOUNCE_GEN_SEED_LOAD_EN
  input  logic [15:0] seed_i,
  input  logic        seed_load_i,
`endif
  output logic        sw_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned SEG_W    = $clog2(MAX_DELAY + 1);
  localparam int unsigned BNC_W    = (N_BOUNCES > 0) ? $clog2(2 * N_BOUNCES + 1) : 1;
  localparam int unsigned SET_W    = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned BNC_INIT = (N_BOUNCES > 0) ? 2 * N_BOUNCES - 1 : 0;
  localparam logic [15:0] SEED_FIX = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] SPAN     = 16'(MAX_DELAY - MIN_DELAY);
  localparam logic [15:0] MIN_W    = 16'(MIN_DELAY);
  localparam logic [SEG_W-1:0] SEG_ONE = SEG_W'(1);
  localparam logic [BNC_W-1:0] BNC_ONE = BNC_W'(1);
  localparam logic [SET_W-1:0] SET_ONE = SET_W'(1);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  state_t           state_q, state_d;
  logic             sw_q, sw_d;
  logic             tgt_q, tgt_d;
  logic             done_q, done_d;
  logic [15:0]      lfsr_q, lfsr_d, lfsr_cur, lfsr_adv;
  logic [SEG_W-1:0] seg_q, seg_d, seg_len;
  logic [BNC_W-1:0] bnc_q, bnc_d;
  logic [SET_W-1:0] set_q, set_d;

  // A seed load in IDLE takes effect in the same cycle, so a coincident start uses it.
  always_comb begin
    lfsr_cur = lfsr_q;
`ifdef BOUNCE_GEN_SEED_LOAD_EN
    if (state_q == IDLE && seed_load_i)
      lfsr_cur = (seed_i == 16'h0) ? 16'hACE1 : seed_i;
`endif
    lfsr_adv = {1'b0, lfsr_cur[15:1]} ^ (lfsr_cur[0] ? 16'hB400 : 16'h0000);
    seg_len  = SEG_W'(MIN_W + (lfsr_cur & SPAN));
  end

  always_comb begin
    state_d = state_q;
    sw_d    = sw_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    lfsr_d  = lfsr_cur;
    seg_d   = seg_q;
    bnc_d   = bnc_q;
    set_d   = set_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          tgt_d = level_i;
          sw_d  = level_i;
          if (N_BOUNCES == 0) begin
            state_d = SETTLE;
            set_d   = SET_W'(SETTLE_CYCLES);
          end else begin
            state_d = BOUNCE;
            seg_d   = seg_len;
            lfsr_d  = lfsr_adv;
            bnc_d   = BNC_W'(BNC_INIT);
          end
        end
      end
      BOUNCE: begin
        // bnc_q counts segments still to be loaded after the current one
        if (seg_q == SEG_ONE) begin
          if (bnc_q == '0) begin
            state_d = SETTLE;
            sw_d    = tgt_q;
            set_d   = SET_W'(SETTLE_CYCLES);
          end else begin
            sw_d   = ~sw_q;
            seg_d  = seg_len;
            lfsr_d = lfsr_adv;
            bnc_d  = bnc_q - BNC_ONE;
          end
        end else begin
          seg_d = seg_q - SEG_ONE;
        end
      end
      SETTLE: begin
        if (set_q == SET_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          set_d = set_q - SET_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sw_q    <= 1'b0;
      tgt_q   <= 1'b0;
      done_q  <= 1'b0;
      lfsr_q  <= SEED_FIX;
      seg_q   <= '0;
      bnc_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      lfsr_q  <= lfsr_d;
      seg_q   <= seg_d;
      bnc_q   <= bnc_d;
      set_q   <= set_d;
    end
  end

  assign sw_o   = sw_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule
